// File: rtl/sh7034_wdt_pkg.sv
// Shared types, constants and helpers for the SH7034 watchdog timer.
package sh7034_wdt_pkg;

  localparam int unsigned ADDR_W  = 28;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BA_W    = 4;
  localparam int unsigned PRESC_W = 13;
  localparam int unsigned CNT_W   = 8;

  localparam logic [ADDR_W-1:0] ADDR_WTCSR  = 28'h5FFFFB8;
  localparam logic [ADDR_W-1:0] ADDR_RSTCSR = 28'h5FFFFBA;

  // Lane patterns for the only accepted (16-bit) writes
  localparam logic [BA_W-1:0] LANES_HI = 4'b1100;
  localparam logic [BA_W-1:0] LANES_LO = 4'b0011;

  localparam logic [7:0]  KEY_5A   = 8'h5A;
  localparam logic [7:0]  KEY_A5   = 8'hA5;
  localparam logic [15:0] WOVF_CLR = 16'hA500;

  typedef struct packed {
    logic       ovf;
    logic       wtit;
    logic       tme;
    logic [1:0] rsvd;
    logic [2:0] cks;
  } wtcsr_t;

  typedef struct packed {
    logic       wovf;
    logic       rste;
    logic       rsts;
    logic [4:0] rsvd;
  } rstcsr_t;

  localparam wtcsr_t  WTCSR_INIT  = wtcsr_t'(8'h18);
  localparam rstcsr_t RSTCSR_INIT = rstcsr_t'(8'h1F);

  // Bits that always read back as 1
  localparam logic [7:0] WTCSR_RMASK  = 8'h18;
  localparam logic [7:0] RSTCSR_RMASK = 8'h1F;

  // Prescaler low-bit mask per CKS; a tick fires when the masked bits wrap to 0
  function automatic logic [PRESC_W-1:0] cks_mask(input logic [2:0] cks);
    logic [PRESC_W-1:0] m;
    case (cks)
      3'd0:    m = 13'h0001;
      3'd1:    m = 13'h003F;
      3'd2:    m = 13'h007F;
      3'd3:    m = 13'h00FF;
      3'd4:    m = 13'h01FF;
      3'd5:    m = 13'h03FF;
      3'd6:    m = 13'h0FFF;
      default: m = 13'h1FFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sh7034_wdt.sv
// SH7034 watchdog timer: prescaler, WTCNT, overflow pulse generator and register file.
module sh7034_wdt
  import sh7034_wdt_pkg::*;
#(
  parameter int unsigned WDTOVF_LEN = 128,
  parameter int unsigned RST_LEN    = 512
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE_R,
  input  logic              CE_F,
  input  logic              RES_N,
  input  logic [ADDR_W-1:0] IBUS_A,
  input  logic [DATA_W-1:0] IBUS_DI,
  output logic [DATA_W-1:0] IBUS_DO,
  input  logic [BA_W-1:0]   IBUS_BA,
  input  logic              IBUS_WE,
  input  logic              IBUS_REQ,
  output logic              IBUS_BUSY,
  output logic              IBUS_ACT,
  output logic              WDT_IRQ,
  output logic              WDTOVF_N,
  output logic              WDT_RST
);

  localparam int unsigned OVF_CNT_W = (WDTOVF_LEN > 1) ? $clog2(WDTOVF_LEN) : 1;
  localparam int unsigned RST_CNT_W = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;

  wtcsr_t                 wtcsr_q, wtcsr_d;
  rstcsr_t                rstcsr_q, rstcsr_d;
  logic [CNT_W-1:0]       wtcnt_q, wtcnt_d;
  logic [PRESC_W-1:0]     presc_q, presc_d, presc_inc;
  logic                   ovf_arm_q, ovf_arm_d;
  logic [OVF_CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;
  logic [RST_CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic                   wdtovf_n_q, wdtovf_n_d;
  logic                   wdt_rst_q, wdt_rst_d;
  logic                   wdt_irq_q, wdt_irq_d;
  logic [DATA_W-1:0]      do_q, do_d;

  logic wr_cyc, wr_csr, wr_cnt, wr_ctl, wr_rcsr, wr_wovf_clr, wr_rste;
  logic rd_cyc, tick, ovfl;

  // Bus decode and tick/overflow detection
  always_comb begin
    IBUS_ACT    = (IBUS_A[ADDR_W-1:2] == ADDR_WTCSR[ADDR_W-1:2]);
    wr_cyc      = CE_R & IBUS_REQ & IBUS_WE;
    wr_csr      = wr_cyc & (IBUS_A == ADDR_WTCSR) & (IBUS_BA == LANES_HI);
    wr_cnt      = wr_csr & (IBUS_DI[31:24] == KEY_5A);
    wr_ctl      = wr_csr & (IBUS_DI[31:24] == KEY_A5);
    wr_rcsr     = wr_cyc & (IBUS_A == ADDR_RSTCSR) & (IBUS_BA == LANES_LO);
    wr_wovf_clr = wr_rcsr & (IBUS_DI[15:0] == WOVF_CLR);
    wr_rste     = wr_rcsr & (IBUS_DI[15:8] == KEY_5A);
    rd_cyc      = CE_F & IBUS_REQ & ~IBUS_WE & IBUS_ACT;
    presc_inc   = presc_q + PRESC_W'(1);
    tick        = CE_R & wtcsr_q.tme & ((presc_inc & cks_mask(wtcsr_q.cks)) == '0);
    ovfl        = tick & ~wr_cnt & (wtcnt_q == 8'hFF);
  end

  // Next-state for counters, registers and pulse outputs
  always_comb begin
    wtcsr_d    = wtcsr_q;
    rstcsr_d   = rstcsr_q;
    wtcnt_d    = wtcnt_q;
    presc_d    = presc_q;
    ovf_arm_d  = ovf_arm_q;
    ovf_cnt_d  = ovf_cnt_q;
    rst_cnt_d  = rst_cnt_q;
    wdtovf_n_d = wdtovf_n_q;
    wdt_rst_d  = wdt_rst_q;
    wdt_irq_d  = wtcsr_q.ovf & ~wtcsr_q.wtit & wtcsr_q.tme;
    do_d       = do_q;

    if (CE_R) begin
      presc_d = wtcsr_q.tme ? presc_inc : '0;
    end

    // A WTCNT write beats a coincident tick
    if (wr_cnt) begin
      wtcnt_d = IBUS_DI[23:16];
    end else if (tick) begin
      wtcnt_d = wtcnt_q + CNT_W'(1);
    end

    if (wr_ctl) begin
      wtcsr_d.wtit = IBUS_DI[22];
      wtcsr_d.tme  = IBUS_DI[21];
      wtcsr_d.cks  = IBUS_DI[18:16];
      if (!IBUS_DI[23] && ovf_arm_q) begin
        wtcsr_d.ovf = 1'b0;
        ovf_arm_d   = 1'b0;
      end
    end

    if (rd_cyc) begin
      do_d = {(wtcsr_q | WTCSR_RMASK), wtcnt_q, (rstcsr_q | RSTCSR_RMASK), 8'hFF};
      if (wtcsr_q.ovf) begin
        ovf_arm_d = 1'b1;
      end
    end

    if (wr_wovf_clr) begin
      rstcsr_d.wovf = 1'b0;
    end
    if (wr_rste) begin
      rstcsr_d.rste = IBUS_DI[6];
      rstcsr_d.rsts = IBUS_DI[5];
    end

    // Running pulses count down on each CE_R
    if (CE_R && !wdtovf_n_q) begin
      if (ovf_cnt_q == '0) wdtovf_n_d = 1'b1;
      else                 ovf_cnt_d  = ovf_cnt_q - OVF_CNT_W'(1);
    end
    if (CE_R && wdt_rst_q) begin
      if (rst_cnt_q == '0) wdt_rst_d = 1'b0;
      else                 rst_cnt_d = rst_cnt_q - RST_CNT_W'(1);
    end

    // Overflow sets flags and (re)starts pulses; it wins over a same-cycle clear
    if (ovfl) begin
      if (!wtcsr_q.wtit) begin
        wtcsr_d.ovf = 1'b1;
        ovf_arm_d   = 1'b0;
      end else begin
        rstcsr_d.wovf = 1'b1;
        wdtovf_n_d    = 1'b0;
        ovf_cnt_d     = OVF_CNT_W'(WDTOVF_LEN - 1);
        if (rstcsr_q.rste) begin
          wdt_rst_d = 1'b1;
          rst_cnt_d = RST_CNT_W'(RST_LEN - 1);
        end
      end
    end

    // Chip reset pin: reinit timer state, abort pulses, keep RSTCSR
    if (CE_R && !RES_N) begin
      wtcsr_d    = WTCSR_INIT;
      wtcnt_d    = '0;
      presc_d    = '0;
      ovf_arm_d  = 1'b0;
      ovf_cnt_d  = '0;
      rst_cnt_d  = '0;
      wdtovf_n_d = 1'b1;
      wdt_rst_d  = 1'b0;
    end

    wtcsr_d.rsvd  = WTCSR_INIT.rsvd;
    rstcsr_d.rsvd = RSTCSR_INIT.rsvd;
  end

  // State registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wtcsr_q    <= WTCSR_INIT;
      rstcsr_q   <= RSTCSR_INIT;
      wtcnt_q    <= '0;
      presc_q    <= '0;
      ovf_arm_q  <= 1'b0;
      ovf_cnt_q  <= '0;
      rst_cnt_q  <= '0;
      wdtovf_n_q <= 1'b1;
      wdt_rst_q  <= 1'b0;
      wdt_irq_q  <= 1'b0;
      do_q       <= '0;
    end else begin
      wtcsr_q    <= wtcsr_d;
      rstcsr_q   <= rstcsr_d;
      wtcnt_q    <= wtcnt_d;
      presc_q    <= presc_d;
      ovf_arm_q  <= ovf_arm_d;
      ovf_cnt_q  <= ovf_cnt_d;
      rst_cnt_q  <= rst_cnt_d;
      wdtovf_n_q <= wdtovf_n_d;
      wdt_rst_q  <= wdt_rst_d;
      wdt_irq_q  <= wdt_irq_d;
      do_q       <= do_d;
    end
  end

  assign IBUS_DO   = do_q;
  assign IBUS_BUSY = 1'b0;
  assign WDT_IRQ   = wdt_irq_q;
  assign WDTOVF_N  = wdtovf_n_q;
  assign WDT_RST   = wdt_rst_q;

endmodule
